// File: rtl/uart_encoder.sv
// UART transmitter: a 4-entry byte FIFO feeds a start/data/parity/stop serializer.
// The serializer runs back-to-back frames whenever the FIFO still holds bytes at the end of a stop bit.
module uart_encoder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_EN    = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_tx,
    output logic       busy,
    output logic [2:0] fifo_count
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // 17 bits covers the longest stop period (2 * 65535 clocks).
    localparam logic [16:0] BIT_RELOAD  = 17'(CLKS_PER_BIT - 1);
    localparam logic [16:0] STOP_RELOAD = 17'(STOP_BITS * CLKS_PER_BIT - 1);

    function automatic logic even_parity(input logic [7:0] d);
        return ^d;
    endfunction

    state_t      state_r;
    logic [7:0]  fifo_mem_r [4];
    logic [1:0]  wr_ptr_r;
    logic [1:0]  rd_ptr_r;
    logic [2:0]  count_r;
    logic [16:0] bit_cnt_r;
    logic [2:0]  bit_idx_r;
    logic [7:0]  shift_r;
    logic        parity_r;
    logic        tx_r;
    logic        push_s;
    logic        pop_s;
    logic [7:0]  head_s;

    assign tx_ready   = (count_r != 3'd4);
    assign fifo_count = count_r;
    assign uart_tx    = tx_r;
    assign busy       = (state_r != IDLE) || (count_r != 3'd0);
    assign push_s     = tx_valid && (count_r != 3'd4);
    assign head_s     = fifo_mem_r[rd_ptr_r];

    // Pop when idle, or at the last clock of the stop period so the next frame follows without a gap.
    always_comb begin
        pop_s = 1'b0;
        if (count_r != 3'd0) begin
            if (state_r == IDLE) begin
                pop_s = 1'b1;
            end else if ((state_r == STOP) && (bit_cnt_r == 17'd0)) begin
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= 2'd0;
            rd_ptr_r <= 2'd0;
            count_r  <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                fifo_mem_r[i] <= 8'h00;
            end
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= tx_data;
                wr_ptr_r             <= wr_ptr_r + 2'd1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 2'd1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 3'd1;
                2'b01:   count_r <= count_r - 3'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Frame serializer; uart_tx is registered and driven with each bit as its period begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            tx_r      <= 1'b1;
            bit_cnt_r <= 17'd0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            parity_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        shift_r   <= head_s;
                        parity_r  <= even_parity(head_s);
                        tx_r      <= 1'b0;
                        bit_cnt_r <= BIT_RELOAD;
                        state_r   <= START;
                    end else begin
                        tx_r <= 1'b1;
                    end
                end
                START: begin
                    if (bit_cnt_r == 17'd0) begin
                        tx_r      <= shift_r[0];
                        shift_r   <= {1'b0, shift_r[7:1]};
                        bit_idx_r <= 3'd0;
                        bit_cnt_r <= BIT_RELOAD;
                        state_r   <= DATA;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 17'd1;
                    end
                end
                DATA: begin
                    if (bit_cnt_r == 17'd0) begin
                        if (bit_idx_r == 3'd7) begin
                            if (PARITY_EN != 0) begin
                                tx_r      <= parity_r;
                                bit_cnt_r <= BIT_RELOAD;
                                state_r   <= PARITY;
                            end else begin
                                tx_r      <= 1'b1;
                                bit_cnt_r <= STOP_RELOAD;
                                state_r   <= STOP;
                            end
                        end else begin
                            tx_r      <= shift_r[0];
                            shift_r   <= {1'b0, shift_r[7:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                            bit_cnt_r <= BIT_RELOAD;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 17'd1;
                    end
                end
                PARITY: begin
                    if (bit_cnt_r == 17'd0) begin
                        tx_r      <= 1'b1;
                        bit_cnt_r <= STOP_RELOAD;
                        state_r   <= STOP;
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 17'd1;
                    end
                end
                STOP: begin
                    if (bit_cnt_r == 17'd0) begin
                        if (pop_s) begin
                            shift_r   <= head_s;
                            parity_r  <= even_parity(head_s);
                            tx_r      <= 1'b0;
                            bit_cnt_r <= BIT_RELOAD;
                            state_r   <= START;
                        end else begin
                            tx_r    <= 1'b1;
                            state_r <= IDLE;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r - 17'd1;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_encoder.sv
// Bench for uart_encoder: three configurations share one clock; a serial decoder
// checks every line sample against bytes queued in a scoreboard when they are pushed.
module tb_uart_encoder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] tx_data;
    logic       tb_valid;
    int         sel;

    logic valid_a, ready_a, tx_a, busy_a;
    logic valid_p, ready_p, tx_p, busy_p;
    logic valid_l, ready_l, tx_l, busy_l;
    logic [2:0] cnt_a, cnt_p, cnt_l;

    assign valid_a = tb_valid && (sel == 0);
    assign valid_p = tb_valid && (sel == 1);
    assign valid_l = tb_valid && (sel == 2);

    uart_encoder #(.CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_a),
        .tx_ready(ready_a), .uart_tx(tx_a), .busy(busy_a), .fifo_count(cnt_a));

    uart_encoder #(.CLKS_PER_BIT(4), .STOP_BITS(2), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_p),
        .tx_ready(ready_p), .uart_tx(tx_p), .busy(busy_p), .fifo_count(cnt_p));

    uart_encoder #(.CLKS_PER_BIT(868), .STOP_BITS(1), .PARITY_EN(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(valid_l),
        .tx_ready(ready_l), .uart_tx(tx_l), .busy(busy_l), .fifo_count(cnt_l));

    logic       line_s, ready_s, busy_s;
    logic [2:0] cnt_s;
    assign line_s  = (sel == 1) ? tx_p    : (sel == 2) ? tx_l    : tx_a;
    assign ready_s = (sel == 1) ? ready_p : (sel == 2) ? ready_l : ready_a;
    assign busy_s  = (sel == 1) ? busy_p  : (sel == 2) ? busy_l  : busy_a;
    assign cnt_s   = (sel == 1) ? cnt_p   : (sel == 2) ? cnt_l   : cnt_a;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc = 0;
    int         frames_done = 0;
    int         mon_cpb = 4;
    int         mon_par = 0;
    int         mon_sb = 1;
    bit         mon_en = 1'b1;
    logic [7:0] exp_q [$];
    int         start_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected line level at clock k of a frame carrying byte b.
    function automatic logic exp_bit(input logic [7:0] b, input int k, input int cpb, input int par);
        int slot;
        slot = k / cpb;
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if ((slot == 9) && (par != 0)) return ^b;
        return 1'b1;
    endfunction

    // Serial decoder: finds a start bit, checks every clock of the frame, recovers the byte mid-bit.
    initial begin : decoder
        bit         act;
        int         k;
        int         len;
        int         slot;
        logic [7:0] exp_b;
        logic [7:0] rx;
        act = 1'b0; k = 0; len = 0; exp_b = 8'h00; rx = 8'h00;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                act = 1'b0;
            end else begin
                if (!act && (line_s === 1'b0)) begin
                    act = 1'b1;
                    k   = 0;
                    rx  = 8'h00;
                    len = (10 + mon_par + mon_sb - 1) * mon_cpb;
                    start_q.push_back(cyc);
                    chk("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    exp_b = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
                end
                if (act) begin
                    chk("line_bit", 32'(line_s), 32'(exp_bit(exp_b, k, mon_cpb, mon_par)));
                    slot = k / mon_cpb;
                    if ((slot >= 1) && (slot <= 8) && ((k % mon_cpb) == (mon_cpb / 2)))
                        rx[slot-1] = line_s;
                    if (k == len - 1) begin
                        act = 1'b0;
                        $display("decoder: received byte %02h", rx);
                        chk("rx_byte", 32'(rx), 32'(exp_b));
                        frames_done++;
                    end
                    k++;
                end
            end
        end
    end

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tb_valid = 1'b1;
        #1 chk("push_ready", 32'(ready_s), 32'd1);
        @(posedge clk);
        exp_q.push_back(b);
    endtask

    task automatic wait_frames(input int target, input int limit);
        int i;
        i = 0;
        while ((frames_done < target) && (i < limit)) begin
            @(negedge clk);
            #1;
            i++;
        end
        chk("frame_timeout", 32'(frames_done >= target), 32'd1);
    endtask

    initial begin : stim
        int n_edge, fb, base, s, p1, done_cyc, ns;
        rst_n = 1'b0; tb_valid = 1'b0; tx_data = 8'h00; sel = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_tx", 32'(tx_a), 32'd1);
        chk("rst_ready", 32'(ready_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_count", 32'(cnt_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single byte 0x55: latency, 40-clock frame, busy drop.
        fb = frames_done; base = start_q.size();
        push(8'h55);
        @(negedge clk);
        tb_valid = 1'b0;
        n_edge = cyc;
        #1;
        chk("t1_count", 32'(cnt_s), 32'd1);
        chk("t1_idle_line", 32'(line_s), 32'd1);
        chk("t1_busy", 32'(busy_s), 32'd1);
        wait_frames(fb + 1, 200);
        done_cyc = cyc;
        chk("t1_latency", 32'(start_q[base]), 32'(n_edge + 1));
        chk("t1_len", 32'(done_cyc - start_q[base] + 1), 32'd40);
        chk("t1_busy_stop", 32'(busy_s), 32'd1);
        @(negedge clk);
        #1;
        chk("t1_busy_drop", 32'(busy_s), 32'd0);
        chk("t1_line_idle", 32'(line_s), 32'd1);

        // Five bytes back to back: FIFO fills, frames contiguous and in order.
        fb = frames_done; base = start_q.size();
        push(8'hA5); push(8'h3C); push(8'hFF); push(8'h00); push(8'h81);
        @(negedge clk);
        tb_valid = 1'b0;
        #1;
        chk("t2_full_count", 32'(cnt_s), 32'd4);
        chk("t2_full_ready", 32'(ready_s), 32'd0);
        wait_frames(fb + 5, 400);
        for (int i = 1; i < 5; i++)
            chk("t2_gap", 32'(start_q[base + i] - start_q[base + i - 1]), 32'd40);
        repeat (3) @(negedge clk);

        // Push coinciding with a pop: occupancy holds at 3 and order is kept.
        fb = frames_done;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
        @(negedge clk);
        tb_valid = 1'b0;
        #1 chk("t3_full", 32'(cnt_s), 32'd4);
        for (int i = 0; (i < 100) && (cnt_s != 3'd3); i++) begin
            @(negedge clk);
            #1;
        end
        chk("t3_drop", 32'(cnt_s), 32'd3);
        p1 = start_q[start_q.size() - 1];
        while (cyc < p1 + 39) @(negedge clk);
        tx_data = 8'h66; tb_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(8'h66);
        @(negedge clk);
        tb_valid = 1'b0;
        #1 chk("t3_count_hold", 32'(cnt_s), 32'd3);
        wait_frames(fb + 6, 600);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of 0x0F with two bytes queued.
        push(8'h0F); push(8'hA1); push(8'hB2);
        @(negedge clk);
        tb_valid = 1'b0;
        s = start_q[start_q.size() - 1];
        while (cyc < s + 21) @(negedge clk);
        #1;
        chk("t4_pre_line", 32'(line_s), 32'd0);
        chk("t4_pre_count", 32'(cnt_s), 32'd2);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("t4_async_tx", 32'(tx_a), 32'd1);
        chk("t4_async_count", 32'(cnt_a), 32'd0);
        chk("t4_async_ready", 32'(ready_a), 32'd1);
        chk("t4_async_busy", 32'(busy_a), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 mon_en = 1'b1;
        fb = frames_done; ns = start_q.size();
        repeat (60) @(negedge clk);
        #1;
        chk("t4_no_frames", 32'(frames_done), 32'(fb));
        chk("t4_no_start", 32'(start_q.size()), 32'(ns));
        chk("t4_line_idle", 32'(tx_a), 32'd1);

        // First push after reset keeps the one-edge latency.
        base = start_q.size();
        push(8'h5A);
        @(negedge clk);
        tb_valid = 1'b0;
        n_edge = cyc;
        wait_frames(fb + 1, 200);
        chk("t4_latency", 32'(start_q[base]), 32'(n_edge + 1));
        repeat (3) @(negedge clk);

        // Parity and two stop bits: 0x07 gives parity 1 and a 48-clock frame.
        sel = 1; mon_par = 1; mon_sb = 2;
        fb = frames_done; base = start_q.size();
        push(8'h07);
        @(negedge clk);
        tb_valid = 1'b0;
        wait_frames(fb + 1, 200);
        done_cyc = cyc;
        chk("t5_len", 32'(done_cyc - start_q[base] + 1), 32'd48);
        @(negedge clk);
        #1 chk("t5_busy_drop", 32'(busy_s), 32'd0);

        // "\r\n" at full baud divisor.
        sel = 2; mon_cpb = 868; mon_par = 0; mon_sb = 1;
        fb = frames_done; base = start_q.size();
        push(8'h0D); push(8'h0A);
        @(negedge clk);
        tb_valid = 1'b0;
        wait_frames(fb + 2, 20000);
        chk("t6_gap", 32'(start_q[base + 1] - start_q[base]), 32'd8680);
        @(negedge clk);
        #1 chk("t6_busy_drop", 32'(busy_s), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
